// File: rtl/pe_tail_collector_pkg.sv
// rtl/pe_tail_collector_pkg.sv - shared widths and FSM encoding for the PE tail collector
package pe_tail_collector_pkg;

    localparam int V_E_F_Bit = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_COLLECT = S_COLLECT,
        ST_REPORT  = S_REPORT
    } state_t;

endpackage

// File: rtl/pe_tail_collector_sw_max_tracker.sv
// rtl/pe_tail_collector_sw_max_tracker.sv - registered running maximum with its index
module sw_max_tracker #(
    parameter int W     = 16,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic [W-1:0]     value,
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     maxVal,
    output logic [IDX_W-1:0] maxIdx
);

    // Strict greater-than keeps the earliest index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxVal <= '0;
            maxIdx <= '0;
        end else if (clear) begin
            maxVal <= '0;
            maxIdx <= '0;
        end else if (update && (value > maxVal)) begin
            maxVal <= value;
            maxIdx <= idx;
        end
    end

endmodule

// File: rtl/pe_tail_collector.sv
// rtl/pe_tail_collector.sv - consumes the last PE stream, fills the boundary buffer, reports best score per pass
module pe_tail_collector
    import pe_tail_collector_pkg::*;
#(
    parameter int W      = V_E_F_Bit,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   t_len,
    input  logic              write_back,
    input  logic              pe_valid,
    input  logic              newLineIn,
    input  logic [1:0]        tIn,
    input  logic [W-1:0]      vIn,
    input  logic [W-1:0]      vIn_alpha,
    input  logic [W-1:0]      fIn,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [W-1:0]      buf_v,
    output logic [W-1:0]      buf_v_alpha,
    output logic [W-1:0]      buf_f,
    output logic [1:0]        buf_t,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [W-1:0]      max_score,
    output logic [ADDR_W-1:0] max_col,
    output logic              frame_err
);

    state_t            state, stateNext;
    logic [ADDR_W:0]   tLenQ;
    logic              writeBackQ;
    logic [ADDR_W-1:0] col;
    logic              startAcc;
    logic              sample;
    logic              frameBad;
    logic              lastSample;
    logic [ADDR_W-1:0] sampleCol;

    // A newLine always resynchronises the column to 0, even out of place.
    assign sampleCol  = newLineIn ? '0 : col;
    assign frameBad   = newLineIn != (col == '0);
    assign lastSample = ({1'b0, sampleCol} == (tLenQ - {{ADDR_W{1'b0}}, 1'b1}));

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_REPORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        startAcc  = 1'b0;
        sample    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    startAcc  = 1'b1;
                    stateNext = (t_len == '0) ? ST_REPORT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (pe_valid) begin
                    sample = 1'b1;
                    if (lastSample) begin
                        stateNext = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tLenQ       <= '0;
            writeBackQ  <= 1'b0;
            col         <= '0;
            frame_err   <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_v       <= '0;
            buf_v_alpha <= '0;
            buf_f       <= '0;
            buf_t       <= '0;
        end else begin
            buf_wr_en <= sample && writeBackQ;
            if (startAcc) begin
                tLenQ      <= t_len;
                writeBackQ <= write_back;
                col        <= '0;
                frame_err  <= 1'b0;
            end
            if (sample) begin
                col         <= sampleCol + ADDR_W'(1);
                buf_wr_addr <= sampleCol;
                buf_v       <= vIn;
                buf_v_alpha <= vIn_alpha;
                buf_f       <= fIn;
                buf_t       <= tIn;
                if (frameBad) begin
                    frame_err <= 1'b1;
                end
            end
            // Stray samples after the last column are dropped but flagged.
            if ((state == ST_REPORT) && pe_valid) begin
                frame_err <= 1'b1;
            end
        end
    end

    sw_max_tracker #(
        .W     (W),
        .IDX_W (ADDR_W)
    ) u_max (
        .clk    (clk),
        .rst    (rst),
        .clear  (startAcc),
        .update (sample),
        .value  (vIn),
        .idx    (sampleCol),
        .maxVal (max_score),
        .maxIdx (max_col)
    );

endmodule

// File: tb/tb_pe_tail_collector.sv
// tb/tb_pe_tail_collector.sv - self-checking bench for pe_tail_collector
module tb_pe_tail_collector;

    localparam int W      = 16;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   t_len;
    logic              write_back;
    logic              pe_valid;
    logic              newLineIn;
    logic [1:0]        tIn;
    logic [W-1:0]      vIn;
    logic [W-1:0]      vIn_alpha;
    logic [W-1:0]      fIn;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [W-1:0]      buf_v;
    logic [W-1:0]      buf_v_alpha;
    logic [W-1:0]      buf_f;
    logic [1:0]        buf_t;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [W-1:0]      max_score;
    logic [ADDR_W-1:0] max_col;
    logic              frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int vfix[$];

    pe_tail_collector #(.W(W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .t_len        (t_len),
        .write_back   (write_back),
        .pe_valid     (pe_valid),
        .newLineIn    (newLineIn),
        .tIn          (tIn),
        .vIn          (vIn),
        .vIn_alpha    (vIn_alpha),
        .fIn          (fIn),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_v        (buf_v),
        .buf_v_alpha  (buf_v_alpha),
        .buf_f        (buf_f),
        .buf_t        (buf_t),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .max_score    (max_score),
        .max_col      (max_col),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, buf_wr_en, 0);
        chk({tag, "_addr"}, buf_wr_addr, 0);
        chk({tag, "_bufv"}, buf_v, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_max"}, max_score, 0);
        chk({tag, "_maxcol"}, max_col, 0);
        chk({tag, "_ferr"}, frame_err, 0);
    endtask

    // errMode: 0 clean framing, 1 extra newLine on 3rd sample, 2 newLine missing on 1st sample
    task automatic do_pass(input int tlen, input bit wb, input int errMode, input int maxBubble,
                           input int hold, input bit startGlitch, input bit reportPv);
        int col = 0;
        int maxv = 0;
        int maxc = 0;
        int sc;
        int i = 0;
        bit ferr = 0;
        bit last = 0;
        bit nl;
        logic [W-1:0] v, va, f;
        logic [1:0] t;

        start = 1; t_len = (ADDR_W+1)'(tlen); write_back = wb;
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("rv_after_start", result_valid, tlen == 0);
        chk("max_cleared", max_score, 0);
        chk("ferr_cleared", frame_err, 0);

        while (!last && tlen != 0 && i < 4000) begin
            repeat ($urandom_range(0, maxBubble)) begin
                pe_valid = 0;
                tick();
                chk("bubble_no_wr", buf_wr_en, 0);
                chk("bubble_rv", result_valid, 0);
            end
            nl = (col == 0);
            if (errMode == 1 && i == 2) nl = 1;
            if (errMode == 2 && i == 0) nl = 0;
            v  = (vfix.size() != 0) ? W'(vfix.pop_front()) : W'($urandom_range(0, 40));
            va = W'($urandom);
            f  = W'($urandom);
            t  = 2'($urandom);
            pe_valid = 1; newLineIn = nl; vIn = v; vIn_alpha = va; fIn = f; tIn = t;
            if (startGlitch && i == 1) begin
                start = 1; t_len = 1; write_back = ~wb;
            end
            tick();
            pe_valid = 0; newLineIn = 0; start = 0; t_len = (ADDR_W+1)'(tlen); write_back = wb;

            sc = nl ? 0 : col;
            if (nl != (col == 0)) ferr = 1;
            if (v > maxv) begin
                maxv = v;
                maxc = sc;
            end
            col  = sc + 1;
            last = (sc == tlen - 1);

            chk("wr_en", buf_wr_en, wb);
            if (wb) begin
                chk("wr_addr", buf_wr_addr, sc);
                chk("wr_v", buf_v, v);
                chk("wr_va", buf_v_alpha, va);
                chk("wr_f", buf_f, f);
                chk("wr_t", buf_t, t);
            end
            chk("max_score", max_score, maxv);
            chk("max_col", max_col, maxc);
            chk("frame_err", frame_err, ferr);
            chk("rv_on_last", result_valid, last);
            chk("busy_collect", busy, 1);
            i++;
        end
        if (tlen != 0 && !last) chk("pass_bound", 0, 1);

        for (int h = 0; h < hold; h++) begin
            if (reportPv && h == 1) begin
                pe_valid = 1; newLineIn = 1; vIn = 16'hFFFF;
                ferr = 1;
            end
            tick();
            pe_valid = 0; newLineIn = 0;
            chk("hold_rv", result_valid, 1);
            chk("hold_max", max_score, maxv);
            chk("hold_col", max_col, maxc);
            chk("hold_ferr", frame_err, ferr);
            chk("hold_no_wr", buf_wr_en, 0);
        end
        result_ready = 1;
        tick();
        result_ready = 0;
        chk("accept_rv", result_valid, 0);
        chk("accept_busy", busy, 0);
    endtask

    initial begin
        rst = 1; start = 0; t_len = 0; write_back = 0; pe_valid = 0; newLineIn = 0;
        tIn = 0; vIn = 0; vIn_alpha = 0; fIn = 0; result_ready = 0;
        repeat (2) tick();
        chk_all_zero("reset");
        @(negedge clk); rst = 0;
        tick();
        chk("idle_busy", busy, 0);

        vfix = {3, 7, 7, 2};
        do_pass(4, 1, 0, 0, 5, 0, 0);
        do_pass(5, 1, 1, 0, 1, 0, 0);
        do_pass(8, 0, 0, 3, 1, 0, 0);
        do_pass(0, 1, 0, 0, 2, 0, 0);
        do_pass(3, 1, 0, 0, 3, 0, 1);
        do_pass(6, 1, 0, 1, 1, 1, 0);
        do_pass(4, 1, 2, 0, 1, 0, 0);
        vfix = {16'h7FFF, 16'hFFFF, 16'h8000, 16'hFFFF};
        do_pass(4, 1, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of COLLECT
        start = 1; t_len = 6; write_back = 1;
        tick();
        start = 0;
        vfix = {9, 5};
        for (int k = 0; k < 2; k++) begin
            pe_valid = 1; newLineIn = (k == 0); vIn = W'(vfix.pop_front());
            tick();
        end
        pe_valid = 0; newLineIn = 0;
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk); rst = 0;
        tick();
        do_pass(5, 1, 0, 1, 1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            int hl;
            hl = $urandom_range(1, 4);
            do_pass($urandom_range(1, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    $urandom_range(0, 2), hl, 1'($urandom_range(0, 1)),
                    (hl >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
